if_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. Holds the PC,

---
 rtl/if_prefetch_unit.sv | 131 +++++++++++++
 tb/tb_if_prefetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch front end with in-order prefetch ring and redirect flush
module if_prefetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    inst_ren,
    output logic [ADDR_WIDTH-1:0]   inst_addr,
    input  logic                    inst_gnt,
    input  logic                    inst_rvalid,
    input  logic [DATA_WIDTH-1:0]   inst_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic [ADDR_WIDTH-1:0]   out_pc_next,
    output logic [DATA_WIDTH-1:0]   out_inst,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_LIMIT = (PTR_W + 1)'(DEPTH);

    // Pointers carry one wrap bit above the index so full and empty are distinguishable.
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [PTR_W-1:0]      alloc_ptr;
    logic [PTR_W-1:0]      fill_ptr;
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      discard_cnt;
    logic [DEPTH-1:0]      filled;
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] head_idx;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] live_pending;
    logic [PTR_W:0]   occupancy;
    logic             accept;
    logic             pop;
    logic             resp_keep;
    logic             resp_drop;

    assign alloc_idx    = alloc_ptr[IDX_W-1:0];
    assign fill_idx     = fill_ptr[IDX_W-1:0];
    assign head_idx     = head_ptr[IDX_W-1:0];
    assign count_q      = alloc_ptr - head_ptr;
    assign live_pending = alloc_ptr - fill_ptr;
    // Discarded reads still occupy memory-side slots, so they count against the issue window.
    assign occupancy    = {1'b0, count_q} + {1'b0, discard_cnt};

    // Issue, handshake and response classification; redirect suppresses issue and pop.
    always_comb begin
        inst_ren  = 1'b0;
        out_valid = 1'b0;
        if (rst_n && !redirect) begin
            inst_ren  = (occupancy < OCC_LIMIT);
            out_valid = filled[head_idx];
        end
        accept    = inst_ren && inst_gnt;
        pop       = out_valid && out_ready;
        resp_keep = inst_rvalid && !redirect && (discard_cnt == '0);
        resp_drop = inst_rvalid && !redirect && (discard_cnt != '0);
    end

    assign inst_addr   = fetch_pc;
    assign count       = count_q;
    assign out_pc      = pc_mem[head_idx];
    assign out_inst    = inst_mem[head_idx];
    assign out_pc_next = pc_mem[head_idx] + ADDR_WIDTH'(PC_STEP);

    // Control state: fetch PC, ring pointers, fill flags and stale-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            discard_cnt <= '0;
            filled      <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            filled      <= '0;
            discard_cnt <= discard_cnt + live_pending - {{(PTR_W-1){1'b0}}, inst_rvalid};
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + PTR_ONE;
                fetch_pc  <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (resp_keep) begin
                fill_ptr         <= fill_ptr + PTR_ONE;
                filled[fill_idx] <= 1'b1;
            end
            if (resp_drop) begin
                discard_cnt <= discard_cnt - PTR_ONE;
            end
            if (pop) begin
                head_ptr         <= head_ptr + PTR_ONE;
                filled[head_idx] <= 1'b0;
            end
        end
    end

    // Ring payload: PC captured at accept, instruction captured at kept response.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[alloc_idx] <= fetch_pc;
        end
        if (resp_keep) begin
            inst_mem[fill_idx] <= inst_data;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        inst_rvalid |-> ((live_pending != '0) || (discard_cnt != '0)));

    a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= OCC_LIMIT);

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed and randomized checks for if_prefetch_unit
module tb_if_prefetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic [31:0] out_inst;
    logic [2:0]  count;

    logic [31:0] mq[$];
    int          n_checks;
    int          n_fail;

    if_prefetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(DEPTH),
        .RESET_PC(RPC),
        .PC_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_ren(inst_ren),
        .inst_addr(inst_addr),
        .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid),
        .inst_data(inst_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_pc_next(out_pc_next),
        .out_inst(out_inst),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_gnt    = 1'b0;
        inst_rvalid = 1'b0;
        inst_data   = '0;
        out_ready   = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, sample 1 time unit later, return at the next negedge.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic g,
                        input logic rv_req, input logic rdy,
                        output logic acc, output logic pop, output logic [31:0] ppc,
                        output logic [31:0] pinst, output logic vld);
        redirect    = rd;
        redirect_pc = rpc;
        inst_gnt    = g;
        out_ready   = rdy;
        if (rv_req && mq.size() > 0) begin
            inst_rvalid = 1'b1;
            inst_data   = inst_of(mq.pop_front());
        end else begin
            inst_rvalid = 1'b0;
            inst_data   = 32'hBAD0_0BAD;
        end
        #1;
        acc   = inst_ren && inst_gnt;
        vld   = out_valid;
        pop   = out_valid && out_ready;
        ppc   = out_pc;
        pinst = out_inst;
        if (acc) mq.push_back(inst_addr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        redirect  = 1'b0;
        inst_gnt  = 1'b1;
        out_ready = 1'b1;
        inst_rvalid = 1'b0;
        mq.delete();
        @(negedge clk);
        #1;
        n_checks++; if (inst_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b want 0", inst_ren); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (inst_addr !== RPC) begin n_fail++; $display("FAIL reset_addr got %h want %h", inst_addr, RPC); end
        inst_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst, exp_pc;
        int first_acc, first_vld, npop;
        do_reset();
        first_acc = -1; first_vld = -1; npop = 0; exp_pc = RPC;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (acc && first_acc < 0) first_acc = i;
            if (vld && first_vld < 0) first_vld = i;
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL stream_pc got %h want %h", ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL stream_inst got %h want %h", pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
        end
        n_checks++; if (first_vld - first_acc != 2) begin n_fail++; $display("FAIL stream_latency got %0d want 2", first_vld - first_acc); end
        n_checks++; if (npop != 10) begin n_fail++; $display("FAIL stream_pops got %0d want 10", npop); end
    endtask

    task automatic test_full();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst, exp_pc;
        int nacc, npop;
        do_reset();
        nacc = 0; npop = 0; exp_pc = RPC;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, pop, ppc, pinst, vld);
            if (acc) nacc++;
        end
        n_checks++; if (nacc != 4) begin n_fail++; $display("FAIL full_accepts got %0d want 4", nacc); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
        n_checks++; if (inst_ren !== 1'b0) begin n_fail++; $display("FAIL full_ren got %b want 0", inst_ren); end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL full_pc got %h want %h", ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL full_inst got %h want %h", pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
        end
        n_checks++; if (npop != 10) begin n_fail++; $display("FAIL full_pops got %0d want 10", npop); end
    endtask

    task automatic test_redirect_inflight();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst, exp_pc;
        int nacc, npop;
        do_reset();
        nacc = 0; npop = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, pop, ppc, pinst, vld);
            if (acc) nacc++;
        end
        n_checks++; if (nacc != 3) begin n_fail++; $display("FAIL rdi_accepts got %0d want 3", nacc); end
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, acc, pop, ppc, pinst, vld);
        n_checks++; if (vld !== 1'b0 || acc !== 1'b0) begin n_fail++; $display("FAIL rdi_quiet got vld=%b acc=%b want 0 0", vld, acc); end
        n_checks++; if (dut.discard_cnt !== 3'd3) begin n_fail++; $display("FAIL rdi_discard got %0d want 3", dut.discard_cnt); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rdi_count got %0d want 0", count); end
        exp_pc = 32'h100;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL rdi_pc got %h want %h", ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL rdi_inst got %h want %h", pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
        end
        n_checks++; if (npop < 6) begin n_fail++; $display("FAIL rdi_pops got %0d want >=6", npop); end
    endtask

    task automatic test_redirect_rvalid();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst, exp_pc;
        int npop;
        do_reset();
        npop = 0;
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, pop, ppc, pinst, vld);
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rdr_valid got %b want 0", vld); end
        n_checks++; if (dut.discard_cnt !== 3'd1) begin n_fail++; $display("FAIL rdr_discard got %0d want 1", dut.discard_cnt); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rdr_count got %0d want 0", count); end
        exp_pc = 32'h200;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL rdr_pc got %h want %h", ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL rdr_inst got %h want %h", pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
        end
        n_checks++; if (npop < 6) begin n_fail++; $display("FAIL rdr_pops got %0d want >=6", npop); end
    endtask

    task automatic test_back_to_back();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst, exp_pc;
        int npop;
        do_reset();
        npop = 0;
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, pop, ppc, pinst, vld);
        step(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, acc, pop, ppc, pinst, vld);
        n_checks++; if (dut.discard_cnt !== 3'd2) begin n_fail++; $display("FAIL b2b_discard1 got %0d want 2", dut.discard_cnt); end
        step(1'b1, 32'h400, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
        n_checks++; if (dut.discard_cnt !== 3'd1) begin n_fail++; $display("FAIL b2b_discard2 got %0d want 1", dut.discard_cnt); end
        n_checks++; if (inst_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_addr got %h want 00000400", inst_addr); end
        exp_pc = 32'h400;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL b2b_pc got %h want %h", ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL b2b_inst got %h want %h", pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
        end
        n_checks++; if (npop < 6) begin n_fail++; $display("FAIL b2b_pops got %0d want >=6", npop); end
    endtask

    task automatic test_random();
        logic acc, pop, vld, rd, g, rv, rdy;
        logic [31:0] ppc, pinst, exp_pc, r, rpc;
        int npop, occ;
        do_reset();
        npop = 0; exp_pc = RPC;
        for (int i = 0; i < 10000; i++) begin
            rd  = ($urandom_range(99) < 3);
            r   = $urandom();
            rpc = {r[31:2], 2'b00};
            g   = ($urandom_range(99) < 70);
            rv  = ($urandom_range(99) < 60);
            rdy = ($urandom_range(99) < 70);
            step(rd, rpc, g, rv, rdy, acc, pop, ppc, pinst, vld);
            if (rd) begin
                n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect_valid cyc %0d got %b want 0", i, vld); end
                exp_pc = rpc;
            end
            if (pop) begin
                n_checks++; if (ppc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, ppc, exp_pc); end
                n_checks++; if (pinst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL rnd_inst cyc %0d got %h want %h", i, pinst, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
            occ = int'(count) + int'(dut.discard_cnt);
            n_checks++; if (occ > DEPTH) begin n_fail++; $display("FAIL rnd_occupancy cyc %0d got %0d want <=%0d", i, occ, DEPTH); end
        end
        n_checks++; if (npop < 1000) begin n_fail++; $display("FAIL rnd_progress got %0d pops want >=1000", npop); end
    endtask

    task automatic test_wrap_reset();
        logic acc, pop, vld;
        logic [31:0] ppc, pinst;
        logic [31:0] pcs [3];
        int npop;
        do_reset();
        npop = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc, pop, ppc, pinst, vld);
            if (pop && npop < 3) begin
                pcs[npop] = ppc;
                npop++;
            end
        end
        n_checks++; if (npop != 3) begin n_fail++; $display("FAIL wrap_pops got %0d want 3", npop); end
        n_checks++; if (pcs[0] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0 got %h want fffffff8", pcs[0]); end
        n_checks++; if (pcs[1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc1 got %h want fffffffc", pcs[1]); end
        n_checks++; if (pcs[2] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc2 got %h want 00000000", pcs[2]); end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, pop, ppc, pinst, vld);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", count); end
        n_checks++; if (inst_ren !== 1'b0) begin n_fail++; $display("FAIL midrst_ren got %b want 0", inst_ren); end
        n_checks++; if (inst_addr !== RPC) begin n_fail++; $display("FAIL midrst_addr got %h want %h", inst_addr, RPC); end
        @(negedge clk);
        do_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_gnt = 1'b0;
        inst_rvalid = 1'b0; inst_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect_inflight();
        test_redirect_rvalid();
        test_back_to_back();
        test_random();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
